// File: rtl/pong_frame_renderer.sv
`default_nettype none
// ============================================================================
//  Module   : pong_frame_renderer
//  Purpose  : Two-player Pong game state, advanced once per VGA frame, with
//             zero-latency per-pixel colour generation.
//  Revision : 1.0  initial release
// ============================================================================
module pong_frame_renderer #(
  parameter int BALL_SPEED   = 2,
  parameter int PADDLE_SPEED = 4,
  parameter int MISS_FRAMES  = 60
) (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic [9:0] iCoord_X,
  input  logic [9:0] iCoord_Y,
  input  logic       iV_SYNC,
  input  logic       iL_Up,
  input  logic       iL_Down,
  input  logic       iR_Up,
  input  logic       iR_Down,
  input  logic       iStart,
  output logic [9:0] oRed,
  output logic [9:0] oGreen,
  output logic [9:0] oBlue,
  output logic [3:0] oScore_L,
  output logic [3:0] oScore_R,
  output logic [1:0] oState
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_MISS = 2'd2,
    S_OVER = 2'd3
  } state_t;

  localparam logic        [9:0]  c_bx_home   = 10'd316;
  localparam logic        [8:0]  c_by_home   = 9'd236;
  localparam logic        [8:0]  c_pad_home  = 9'd208;
  localparam logic        [8:0]  c_pad_max   = 9'd416;
  localparam logic signed [10:0] c_ball_step = 11'(BALL_SPEED);
  localparam logic signed [10:0] c_pad_step  = 11'(PADDLE_SPEED);
  localparam int                 c_cnt_w     = (MISS_FRAMES > 1) ? $clog2(MISS_FRAMES) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last  = c_cnt_w'(MISS_FRAMES - 1);

  state_t             state_q;
  logic [9:0]         bx_q;
  logic [8:0]         by_q, ly_q, ry_q;
  logic               dx_q, dy_q;          // 1 = positive direction
  logic [3:0]         score_l_q, score_r_q;
  logic [c_cnt_w-1:0] cnt_q;
  logic               vsync_q;

  logic               w_tick;
  logic signed [10:0] w_bx_step, w_by_step;
  logic               w_l_overlap, w_r_overlap, w_l_hit, w_r_hit, w_miss_left, w_miss_right;
  logic [9:0]         bx_d;
  logic [8:0]         by_d, ly_d, ry_d;
  logic               dx_d, dy_d;

  function automatic logic [8:0] paddle_next(input logic [8:0] pos, input logic up, input logic down);
    logic signed [10:0] s;
    s = $signed({2'b00, pos});
    if (up && !down)      s = s - c_pad_step;
    else if (down && !up) s = s + c_pad_step;
    if (s < 11'sd0)                        return 9'd0;
    else if (s > $signed({2'b00, c_pad_max})) return c_pad_max;
    else                                   return s[8:0];
  endfunction

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v >= 4'd9) ? 4'd9 : v + 4'd1;
  endfunction

  assign w_tick    = vsync_q && !iV_SYNC;
  assign ly_d      = paddle_next(ly_q, iL_Up, iL_Down);
  assign ry_d      = paddle_next(ry_q, iR_Up, iR_Down);
  assign w_bx_step = $signed({1'b0, bx_q}) + (dx_q ? c_ball_step : -c_ball_step);
  assign w_by_step = $signed({2'b00, by_q}) + (dy_q ? c_ball_step : -c_ball_step);

  // Paddle contact is judged against the ball row before this frame's move.
  assign w_l_overlap  = ({1'b0, by_q} <= {1'b0, ly_q} + 10'd63) && ({1'b0, ly_q} <= {1'b0, by_q} + 10'd7);
  assign w_r_overlap  = ({1'b0, by_q} <= {1'b0, ry_q} + 10'd63) && ({1'b0, ry_q} <= {1'b0, by_q} + 10'd7);
  assign w_l_hit      = !dx_q && (w_bx_step <= 11'sd24)  && w_l_overlap;
  assign w_r_hit      =  dx_q && (w_bx_step >= 11'sd608) && w_r_overlap;
  assign w_miss_left  = !w_l_hit && !w_r_hit && (w_bx_step <= 11'sd0);
  assign w_miss_right = !w_l_hit && !w_r_hit && (w_bx_step >= 11'sd632);

  always_comb begin
    by_d = w_by_step[8:0];
    dy_d = dy_q;
    if (w_by_step <= 11'sd0) begin
      by_d = 9'd0;
      dy_d = 1'b1;
    end else if (w_by_step >= 11'sd472) begin
      by_d = 9'd472;
      dy_d = 1'b0;
    end
    bx_d = w_bx_step[9:0];
    dx_d = dx_q;
    if (w_l_hit) begin
      bx_d = 10'd24;
      dx_d = 1'b1;
    end else if (w_r_hit) begin
      bx_d = 10'd608;
      dx_d = 1'b0;
    end else if (w_miss_left) begin
      bx_d = 10'd0;
    end else if (w_miss_right) begin
      bx_d = 10'd632;
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q   <= S_IDLE;
      bx_q      <= c_bx_home;
      by_q      <= c_by_home;
      dx_q      <= 1'b1;
      dy_q      <= 1'b1;
      ly_q      <= c_pad_home;
      ry_q      <= c_pad_home;
      score_l_q <= 4'd0;
      score_r_q <= 4'd0;
      cnt_q     <= '0;
      vsync_q   <= 1'b1;
    end else begin
      vsync_q <= iV_SYNC;
      if (w_tick) begin
        if (state_q != S_OVER) begin
          ly_q <= ly_d;
          ry_q <= ry_d;
        end
        case (state_q)
          S_IDLE: begin
            bx_q <= c_bx_home;
            by_q <= c_by_home;
            if (iStart) begin
              state_q <= S_PLAY;
              dx_q    <= ~(score_l_q[0] ^ score_r_q[0]);
              dy_q    <= 1'b1;
            end
          end
          S_PLAY: begin
            bx_q <= bx_d;
            by_q <= by_d;
            dx_q <= dx_d;
            dy_q <= dy_d;
            if (w_miss_left) begin
              score_r_q <= sat_inc(score_r_q);
              state_q   <= S_MISS;
              cnt_q     <= '0;
            end else if (w_miss_right) begin
              score_l_q <= sat_inc(score_l_q);
              state_q   <= S_MISS;
              cnt_q     <= '0;
            end
          end
          S_MISS: begin
            if (cnt_q == c_cnt_last) begin
              cnt_q   <= '0;
              bx_q    <= c_bx_home;
              by_q    <= c_by_home;
              state_q <= (score_l_q == 4'd9 || score_r_q == 4'd9) ? S_OVER : S_IDLE;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          default: begin
            if (iStart) begin
              score_l_q <= 4'd0;
              score_r_q <= 4'd0;
              ly_q      <= c_pad_home;
              ry_q      <= c_pad_home;
              state_q   <= S_IDLE;
            end
          end
        endcase
      end
    end
  end

  logic w_in_area, w_ball_on, w_pad_on, w_centre_on;

  assign w_in_area   = (iCoord_X < 10'd640) && (iCoord_Y < 10'd480);
  assign w_ball_on   = (state_q == S_IDLE || state_q == S_PLAY)
                     && (iCoord_X >= bx_q) && ({1'b0, iCoord_X} <= {1'b0, bx_q} + 11'd7)
                     && (iCoord_Y >= {1'b0, by_q}) && ({1'b0, iCoord_Y} <= {2'b00, by_q} + 11'd7);
  assign w_pad_on    = ((iCoord_X >= 10'd16) && (iCoord_X <= 10'd23)
                        && (iCoord_Y >= {1'b0, ly_q}) && (iCoord_Y <= {1'b0, ly_q} + 10'd63))
                     || ((iCoord_X >= 10'd616) && (iCoord_X <= 10'd623)
                        && (iCoord_Y >= {1'b0, ry_q}) && (iCoord_Y <= {1'b0, ry_q} + 10'd63));
  assign w_centre_on = ((iCoord_X == 10'd319) || (iCoord_X == 10'd320)) && !iCoord_Y[3];

  always_comb begin
    oRed   = 10'h000;
    oGreen = 10'h000;
    oBlue  = 10'h000;
    if (w_in_area) begin
      if (w_ball_on) begin
        oRed   = 10'h3FF;
        oGreen = 10'h3FF;
        oBlue  = 10'h3FF;
      end else if (w_pad_on) begin
        oGreen = 10'h3FF;
      end else if (w_centre_on) begin
        oRed   = 10'h200;
        oGreen = 10'h200;
        oBlue  = 10'h200;
      end
    end
  end

  assign oScore_L = score_l_q;
  assign oScore_R = score_r_q;
  assign oState   = state_q;

endmodule
`default_nettype wire

// File: doc/pong_frame_renderer.md
PONG_FRAME_RENDERER -- requirements
Module: pong_frame_renderer

Interface
REQ-001 Parameter BALL_SPEED, default 2, ball pixels moved per axis per frame.
REQ-002 Parameter PADDLE_SPEED, default 4, paddle pixels moved per frame.
REQ-003 Parameter MISS_FRAMES, default 60, frames held in MISS before re-serve.
REQ-004 Clock  in  1  pixel clock, shared with the VGA controller.
REQ-005 Resetn  in  1  asynchronous, active-low reset.
REQ-006 iCoord_X  in  10  active-area pixel column, 0..639; other values mean outside the active area.
REQ-007 iCoord_Y  in  10  active-area pixel row, 0..479; other values mean outside the active area.
REQ-008 iV_SYNC  in  1  vertical sync from the VGA controller, active low.
REQ-009 iL_Up, iL_Down, iR_Up, iR_Down  in  1 each  paddle buttons, active high, synchronous to Clock.
REQ-010 iStart  in  1  serve/restart request, active high.
REQ-011 oRed, oGreen, oBlue  out  10 each  pixel colour for the current coordinate.
REQ-012 oScore_L, oScore_R  out  4 each  scores, 0..9.
REQ-013 oState  out  2  game state: 0 IDLE, 1 PLAY, 2 MISS, 3 OVER.

Function
REQ-014 Frame tick: iV_SYNC is registered once; tick is a one-cycle pulse when the registered value is 1 and iV_SYNC is 0 (falling edge); all game state updates occur only on tick.
REQ-015 Colour outputs are combinational from iCoord_X/Y and registered state, with zero added latency; coordinates with X >= 640 or Y >= 480 give colour 0.
REQ-016 Colour priority: ball (8x8 at BX,BY) white 10'h3FF; else paddle (8 wide x 64 tall) green 10'h3FF; else centre line (X 319..320, Y bit 3 = 0) grey 10'h200 on all channels; else black.
REQ-017 Left paddle occupies X 16..23; right paddle occupies X 616..623; paddle tops LY and RY are 9 bits, range 0..416.
REQ-018 Paddle motion on tick, in every state except OVER: Up and not Down subtracts PADDLE_SPEED; Down and not Up adds PADDLE_SPEED; both or neither holds; the result is clamped to 0..416 with no wrap.
REQ-019 IDLE: ball held at (316,236); iStart sampled on tick -> PLAY, with ball direction DX = +1 if (oScore_L + oScore_R) is even, else -1, and DY = +1.
REQ-020 PLAY, on tick: BX += DX*BALL_SPEED and BY += DY*BALL_SPEED, using signed arithmetic computed 1 bit wider than the position.
REQ-021 Vertical bounce: a next BY <= 0 clamps to 0 and sets DY = +1; a next BY >= 472 clamps to 472 and sets DY = -1.
REQ-022 Left hit: DX = -1 and next BX <= 24 and [BY, BY+7] overlaps [LY, LY+63] -> BX = 24, DX = +1.
REQ-023 Right hit: DX = +1 and next BX >= 608 and [BY, BY+7] overlaps [RY, RY+63] -> BX = 608, DX = -1.
REQ-024 Miss: no hit and next BX <= 0 -> oScore_R +1, go to MISS; no hit and next BX >= 632 -> oScore_L +1, go to MISS.
REQ-025 Simultaneous horizontal and vertical boundary events in one tick: both are applied in the same tick.
REQ-026 MISS: a frame counter counts ticks; after MISS_FRAMES ticks -> OVER if either score = 9, else IDLE; the ball is hidden during MISS.
REQ-027 OVER: ball hidden, paddles frozen; iStart on tick clears both scores, recentres the paddles (LY = RY = 208) -> IDLE.
REQ-028 Scores never exceed 9.
REQ-029 iStart outside a tick is ignored; there is no latching of iStart.

Reset
REQ-030 Resetn low asynchronously forces: state IDLE, BX = 316, BY = 236, DX = +1, DY = +1, LY = RY = 208, scores 0, frame counter 0, registered iV_SYNC = 1.
REQ-031 Reset asserted mid-frame or mid-MISS discards all progress; the first tick after release obeys IDLE rules.
REQ-032 During reset, colour outputs still follow REQ-015/REQ-016 using the reset state.

Verification
REQ-033 After reset, coordinate (316,236) -> RGB 3FF/3FF/3FF; (20,210) -> 000/3FF/000; (100,100) -> 000/000/000; (700,10) -> 000/000/000.
REQ-034 iL_Up held for 60 ticks from LY = 208 -> LY clamps at 0 and never wraps; iL_Up and iL_Down held together -> LY unchanged.
REQ-035 PLAY with DY = -1 and BY = 2 -> after one tick BY = 0 and DY = +1.
REQ-036 LY = 208, BY = 230, DX = -1, BX = 26 -> after one tick BX = 24 and DX = +1; same setup with LY = 0 -> MISS and oScore_R = 1 when BX reaches 0.
REQ-037 oScore_R = 8, right scores again -> after 60 ticks state OVER; iStart on tick -> scores 0, IDLE.
REQ-038 Resetn pulsed low mid-MISS -> immediate IDLE, scores 0, ball visible at (316,236).
